// File: rtl/dcache_ctrl_if.sv
// CPU-side and main-memory-side signals of the data cache, bundled for port use.
// slave  : cache view (consumes cpu_* requests and mem_* responses, drives the rest).
// master : environment view (core + memory), the mirror image of slave.
interface dcache_ctrl_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_mem_read;
    logic              cpu_mem_write;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_rd_req;
    logic              mem_wr_req;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport slave (
        input  cpu_addr, cpu_wdata, cpu_mem_read, cpu_mem_write, mem_rdata, mem_ready,
        output cpu_rdata, cpu_stall, mem_addr, mem_wdata, mem_rd_req, mem_wr_req
    );

    modport master (
        output cpu_addr, cpu_wdata, cpu_mem_read, cpu_mem_write, mem_rdata, mem_ready,
        input  cpu_rdata, cpu_stall, mem_addr, mem_wdata, mem_rd_req, mem_wr_req
    );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-through, no-write-allocate data cache with refill/write FSM.
// Latency: read hit 0 cycles; read miss 4 beats of memory latency + 1; store 1 + memory latency.
// Backpressure: cpu_stall holds the core; memory requests are level-held until mem_ready.
// Ports: clk/rst (sync, active-high); bus.cpu_* load/store requests and load data;
//        bus.mem_* word-wide read/write requests to main memory with a one-cycle mem_ready per beat.
module dcache_ctrl #(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 32,
    parameter int INDEX_W  = 5,
    parameter int OFFSET_W = 2
) (
    input  logic           clk,
    input  logic           rst,
    dcache_ctrl_if.slave   bus
);
    localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
    localparam int LINES = 1 << INDEX_W;
    localparam int WORDS = 1 << OFFSET_W;
    localparam logic [OFFSET_W-1:0] BEAT_LAST = '1;

    typedef enum logic [1:0] {IDLE, REFILL, WRITE, WDONE} state_t;

    state_t                state_q, state_d;
    logic [OFFSET_W-1:0]   beat_q;
    logic [LINES-1:0]      valid_q;
    logic [TAG_W-1:0]      tag_q  [LINES];
    logic [DATA_W-1:0]     data_q [LINES*WORDS];

    logic [TAG_W-1:0]      cpu_tag;
    logic [INDEX_W-1:0]    cpu_idx;
    logic [OFFSET_W-1:0]   cpu_off;
    logic                  hit;

    logic                  stall;
    logic                  rd_req;
    logic                  wr_req;
    logic [ADDR_W-1:0]     maddr;
    logic [DATA_W-1:0]     rdata;

    assign cpu_tag = bus.cpu_addr[ADDR_W-1 -: TAG_W];
    assign cpu_idx = bus.cpu_addr[OFFSET_W +: INDEX_W];
    assign cpu_off = bus.cpu_addr[OFFSET_W-1:0];
    assign hit     = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        rd_req  = 1'b0;
        wr_req  = 1'b0;
        maddr   = bus.cpu_addr;
        rdata   = '0;
        case (state_q)
            IDLE: begin
                if (bus.cpu_mem_write) begin
                    // Stores win over loads when both strobes are up.
                    stall   = 1'b1;
                    state_d = WRITE;
                end else if (bus.cpu_mem_read) begin
                    if (hit) begin
                        rdata = data_q[{cpu_idx, cpu_off}];
                    end else begin
                        stall   = 1'b1;
                        state_d = REFILL;
                    end
                end
            end
            REFILL: begin
                stall  = 1'b1;
                rd_req = 1'b1;
                maddr  = {cpu_tag, cpu_idx, beat_q};
                if (bus.mem_ready && beat_q == BEAT_LAST) begin
                    state_d = IDLE;
                end
            end
            WRITE: begin
                stall  = 1'b1;
                wr_req = 1'b1;
                if (bus.mem_ready) begin
                    state_d = WDONE;
                end
            end
            WDONE: begin
                // One unstalled cycle lets the core retire the store.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Reset aborts any transfer in the same cycle it is sampled.
        if (rst) begin
            stall   = 1'b0;
            rd_req  = 1'b0;
            wr_req  = 1'b0;
            state_d = IDLE;
        end
    end

    assign bus.cpu_rdata  = rdata;
    assign bus.cpu_stall  = stall;
    assign bus.mem_addr   = maddr;
    assign bus.mem_wdata  = bus.cpu_wdata;
    assign bus.mem_rd_req = rd_req;
    assign bus.mem_wr_req = wr_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == REFILL && bus.mem_ready) begin
                // Line is invalid while partially filled; set only on the final beat.
                beat_q           <= beat_q + 1'b1;
                valid_q[cpu_idx] <= (beat_q == BEAT_LAST);
            end
        end
    end

    // Tag and data storage carry no reset; writes are suppressed while rst is high.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == REFILL && bus.mem_ready) begin
                data_q[{cpu_idx, beat_q}] <= bus.mem_rdata;
                if (beat_q == BEAT_LAST) begin
                    tag_q[cpu_idx] <= cpu_tag;
                end
            end
            if (state_q == WRITE && bus.mem_ready && hit) begin
                data_q[{cpu_idx, cpu_off}] <= bus.cpu_wdata;
            end
        end
    end
endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: directed loads/stores against a 3-cycle-per-beat memory model.
// Expected memory beats and load results are queued by the stimulus tasks and
// consumed by an independent monitor that watches the DUT outputs.
module tb_dcache_ctrl;
    localparam int LAT = 3;
    localparam logic [1:0] K_RD = 2'd0;
    localparam logic [1:0] K_WR = 2'd1;
    localparam logic [1:0] K_LD = 2'd2;

    typedef struct packed {
        logic [1:0]  kind;
        logic [9:0]  addr;
        logic [31:0] data;
    } ev_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   nbeats = 0;
    ev_t  expq[$];

    dcache_ctrl_if #(.ADDR_W(10), .DATA_W(32)) bus ();

    dcache_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Main memory: mem_ready pulses on the LAT-th cycle a request has been held.
    initial begin
        logic [31:0] mem [1024];
        int cnt;
        cnt = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + i;
        for (int i = 0; i < 4; i++) begin
            mem[10'h010 + i] = 32'hA0 + i;
            mem[10'h090 + i] = 32'hB0 + i;
        end
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (bus.mem_rd_req || bus.mem_wr_req) begin
                cnt++;
                if (cnt == LAT) begin
                    cnt = 0;
                    bus.mem_ready = 1'b1;
                    if (bus.mem_rd_req) begin
                        bus.mem_rdata = mem[bus.mem_addr];
                        nbeats++;
                    end else begin
                        mem[bus.mem_addr] = bus.mem_wdata;
                    end
                end else begin
                    bus.mem_ready = 1'b0;
                end
            end else begin
                cnt = 0;
                bus.mem_ready = 1'b0;
            end
        end
    end

    task automatic sb_check(input ev_t got, input string what);
        ev_t exp;
        total++;
        if (expq.size() == 0) begin
            bad++;
            $display("FAIL %s unexpected: kind=%0d addr=%h data=%h", what, got.kind, got.addr, got.data);
        end else begin
            exp = expq.pop_front();
            if (got !== exp) begin
                bad++;
                $display("FAIL %s: got kind=%0d addr=%h data=%h, want kind=%0d addr=%h data=%h",
                         what, got.kind, got.addr, got.data, exp.kind, exp.addr, exp.data);
            end
        end
    endtask

    // Monitor: memory beats and completed loads, sampled mid-cycle.
    always @(negedge clk) begin
        ev_t got;
        #1;
        if (bus.mem_rd_req && bus.mem_wr_req) begin
            total++;
            bad++;
            $display("FAIL both_req: rd_req=1 wr_req=1, want at most one");
        end
        if (bus.mem_ready && (bus.mem_rd_req || bus.mem_wr_req)) begin
            got.kind = bus.mem_rd_req ? K_RD : K_WR;
            got.addr = bus.mem_addr;
            got.data = bus.mem_rd_req ? bus.mem_rdata : bus.mem_wdata;
            sb_check(got, "mem_beat");
        end
        if (!rst && !bus.cpu_stall && bus.cpu_mem_read && !bus.cpu_mem_write) begin
            got.kind = K_LD;
            got.addr = bus.cpu_addr;
            got.data = bus.cpu_rdata;
            sb_check(got, "load");
        end
    end

    task automatic push_ev(input logic [1:0] k, input logic [9:0] a, input logic [31:0] d);
        ev_t e;
        e.kind = k;
        e.addr = a;
        e.data = d;
        expq.push_back(e);
    endtask

    task automatic check_val(input string what, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h, want %h", what, got, want);
        end
    endtask

    // Waits for the first unstalled cycle; returns number of stalled cycles.
    task automatic wait_unstall(output int n);
        bit done;
        done = 1'b0;
        n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            #2;
            if (!bus.cpu_stall) done = 1'b1;
            else n++;
        end
        if (!done) begin
            bad++;
            $display("FAIL timeout: stall still high after %0d cycles, want release", n);
        end
    endtask

    // Called just after a rising edge; returns just after a rising edge.
    task automatic do_load(input logic [9:0] a, input bit miss,
                           input logic [31:0] d0, input logic [31:0] d1,
                           input logic [31:0] d2, input logic [31:0] d3,
                           input logic [31:0] rd, input int exp_stall);
        logic [31:0] d [4];
        int n;
        d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
        if (miss) begin
            for (int k = 0; k < 4; k++) push_ev(K_RD, {a[9:2], 2'(k)}, d[k]);
        end
        push_ev(K_LD, a, rd);
        bus.cpu_addr      = a;
        bus.cpu_mem_read  = 1'b1;
        bus.cpu_mem_write = 1'b0;
        wait_unstall(n);
        check_val("load_stall_cycles", 32'(n), 32'(exp_stall));
        @(posedge clk);
        #1;
        bus.cpu_mem_read = 1'b0;
    endtask

    task automatic do_store(input logic [9:0] a, input logic [31:0] wd, input bit also_read);
        int n;
        push_ev(K_WR, a, wd);
        bus.cpu_addr      = a;
        bus.cpu_wdata     = wd;
        bus.cpu_mem_write = 1'b1;
        bus.cpu_mem_read  = also_read;
        wait_unstall(n);
        check_val("store_stall_cycles", 32'(n), 32'(1 + LAT));
        check_val("wdone_no_req", {30'd0, bus.mem_rd_req, bus.mem_wr_req}, 32'd0);
        @(posedge clk);
        #1;
        bus.cpu_mem_write = 1'b0;
        bus.cpu_mem_read  = 1'b0;
    endtask

    initial begin
        int guard;
        rst               = 1'b1;
        bus.cpu_addr      = '0;
        bus.cpu_wdata     = '0;
        bus.cpu_mem_read  = 1'b0;
        bus.cpu_mem_write = 1'b0;
        @(posedge clk);
        #1;
        // Missing load held during reset must not stall or request memory.
        bus.cpu_addr     = 10'h010;
        bus.cpu_mem_read = 1'b1;
        @(negedge clk);
        #2;
        check_val("rst_stall", {31'd0, bus.cpu_stall}, 32'd0);
        check_val("rst_reqs", {30'd0, bus.mem_rd_req, bus.mem_wr_req}, 32'd0);
        check_val("rst_rdata", bus.cpu_rdata, 32'd0);
        @(posedge clk);
        #1;
        rst              = 1'b0;
        bus.cpu_mem_read = 1'b0;

        // 1: cold miss refill
        do_load(10'h010, 1'b1, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA0, 4*LAT + 1);
        // 2: hit, zero stall
        do_load(10'h013, 1'b0, 0, 0, 0, 0, 32'hA3, 0);
        // 3: store hit updates cache and memory
        do_store(10'h012, 32'hDEADBEEF, 1'b0);
        do_load(10'h012, 1'b0, 0, 0, 0, 0, 32'hDEADBEEF, 0);
        // 4: conflict eviction on index 4
        do_load(10'h090, 1'b1, 32'hB0, 32'hB1, 32'hB2, 32'hB3, 32'hB0, 4*LAT + 1);
        do_load(10'h093, 1'b0, 0, 0, 0, 0, 32'hB3, 0);
        do_load(10'h010, 1'b1, 32'hA0, 32'hA1, 32'hDEADBEEF, 32'hA3, 32'hA0, 4*LAT + 1);
        do_load(10'h011, 1'b0, 0, 0, 0, 0, 32'hA1, 0);
        // 5: store miss (with read strobe also up) does not allocate
        do_store(10'h200, 32'h55, 1'b1);
        do_load(10'h200, 1'b1, 32'h55, 32'h1000_0201, 32'h1000_0202, 32'h1000_0203, 32'h55, 4*LAT + 1);
        do_load(10'h010, 1'b0, 0, 0, 0, 0, 32'hA0, 0);

        // 6: reset after two beats of a refill
        push_ev(K_RD, 10'h124, 32'h1000_0124);
        push_ev(K_RD, 10'h125, 32'h1000_0125);
        guard = nbeats + 2;
        bus.cpu_addr     = 10'h124;
        bus.cpu_mem_read = 1'b1;
        for (int c = 0; c < 100 && nbeats < guard; c++) begin
            @(negedge clk);
            #2;
        end
        check_val("abort_beats_seen", 32'(nbeats), 32'(guard));
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        #2;
        check_val("abort_rd_req", {31'd0, bus.mem_rd_req}, 32'd0);
        check_val("abort_stall", {31'd0, bus.cpu_stall}, 32'd0);
        @(posedge clk);
        #1;
        rst              = 1'b0;
        bus.cpu_mem_read = 1'b0;
        do_load(10'h124, 1'b1, 32'h1000_0124, 32'h1000_0125, 32'h1000_0126, 32'h1000_0127,
                32'h1000_0124, 4*LAT + 1);
        // Reset cleared every valid bit, so index 4 misses again.
        do_load(10'h013, 1'b1, 32'hA0, 32'hA1, 32'hDEADBEEF, 32'hA3, 32'hA3, 4*LAT + 1);

        repeat (4) @(posedge clk);
        #1;
        check_val("scoreboard_drained", 32'(expq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
